// File: rtl/id_hazard_scheduler.sv
// ID-stage interlock: per-register write scoreboard, RAW stall and branch/jump flush sequencing.
// Optional HAZARD_STATS_EN adds stall_cycles / flush_count statistics outputs.
module id_hazard_scheduler #(
    parameter int CNT_W          = 2,
    parameter int BRANCH_PENALTY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        id_valid,
    input  logic [4:0]  readSelect1,
    input  logic [4:0]  readSelect2,
    input  logic        uses_rs,
    input  logic        uses_rt,
    input  logic        dest_valid,
    input  logic [4:0]  dest_sel,
    input  logic        PCSource,
    input  logic        writeEnable,
    input  logic [4:0]  writeSelect,
    output logic        id_ready,
    output logic        id_issue,
    output logic        id_ex_bubble,
    output logic        pc_hold,
    output logic        if_id_flush,
    output logic [31:0] busy_vec
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [CNT_W-1:0] PEND_MAX   = '1;
    localparam logic [CNT_W-1:0] PEND_ONE   = 1;
    localparam logic [2:0]       FLUSH_INIT = 3'(BRANCH_PENALTY - 1);

    state_t                  state_q, state_d;
    logic [2:0]              flush_q, flush_d;
    logic [31:0][CNT_W-1:0]  pend_q, pend_d;
    logic                    hazard, inc, dec, same_reg;

    // pend_q[0] is never written, so reads of register 0 never see a pending write.
    always_comb begin
        hazard = id_valid & ((uses_rs & (pend_q[readSelect1] != '0))
                           | (uses_rt & (pend_q[readSelect2] != '0))
                           | (dest_valid & (dest_sel != 5'd0) & (pend_q[dest_sel] == PEND_MAX)));
    end

    always_comb begin
        id_ready     = 1'b0;
        id_issue     = 1'b0;
        id_ex_bubble = 1'b0;
        pc_hold      = 1'b0;
        if_id_flush  = 1'b0;
        state_d      = state_q;
        flush_d      = flush_q;
        case (state_q)
            RUN, STALL: begin
                if (hazard) begin
                    id_ex_bubble = 1'b1;
                    pc_hold      = 1'b1;
                    state_d      = STALL;
                end else if (id_valid) begin
                    id_issue = 1'b1;
                    id_ready = 1'b1;
                    state_d  = RUN;
                    if (PCSource) begin
                        if_id_flush = 1'b1;
                        state_d     = FLUSH;
                        flush_d     = FLUSH_INIT;
                    end
                end else begin
                    id_ex_bubble = 1'b1;
                    id_ready     = 1'b1;
                    state_d      = RUN;
                end
            end
            FLUSH: begin
                id_ex_bubble = 1'b1;
                if_id_flush  = 1'b1;
                id_ready     = 1'b1;
                if (flush_q == 3'd0) state_d = RUN;
                else                 flush_d = flush_q - 3'd1;
            end
            default: state_d = RUN;
        endcase
        // Outputs are combinational, so force them quiet while reset is held.
        if (!Reset) begin
            id_ready     = 1'b0;
            id_issue     = 1'b0;
            id_ex_bubble = 1'b0;
            pc_hold      = 1'b0;
            if_id_flush  = 1'b0;
        end
    end

    // A write-back and a new issue to the same register cancel out.
    always_comb begin
        inc      = id_issue & dest_valid & (dest_sel != 5'd0) & (pend_q[dest_sel] != PEND_MAX);
        dec      = writeEnable & (writeSelect != 5'd0) & (pend_q[writeSelect] != '0);
        same_reg = (writeSelect == dest_sel);
        pend_d   = pend_q;
        if (inc && !(dec && same_reg)) pend_d[dest_sel]    = pend_q[dest_sel] + PEND_ONE;
        if (dec && !(inc && same_reg)) pend_d[writeSelect] = pend_q[writeSelect] - PEND_ONE;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) busy_vec[i] = (pend_q[i] != '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            flush_q <= 3'd0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            pend_q  <= pend_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (state_q == STALL && hazard) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (id_issue && PCSource && flush_count_q != 16'hFFFF) flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Self-checking bench for id_hazard_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a per-register pending-count model.
module tb_id_hazard_scheduler;

    localparam int CNT_W   = 2;
    localparam int PENALTY = 2;
    localparam int MAXV    = (1 << CNT_W) - 1;

    logic        Clk, Reset;
    logic        id_valid, uses_rs, uses_rt, dest_valid, PCSource, writeEnable;
    logic [4:0]  readSelect1, readSelect2, dest_sel, writeSelect;
    logic        id_ready, id_issue, id_ex_bubble, pc_hold, if_id_flush;
    logic [31:0] busy_vec;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    id_hazard_scheduler #(.CNT_W(CNT_W), .BRANCH_PENALTY(PENALTY)) dut (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid),
        .readSelect1(readSelect1), .readSelect2(readSelect2),
        .uses_rs(uses_rs), .uses_rt(uses_rt),
        .dest_valid(dest_valid), .dest_sel(dest_sel), .PCSource(PCSource),
        .writeEnable(writeEnable), .writeSelect(writeSelect),
        .id_ready(id_ready), .id_issue(id_issue), .id_ex_bubble(id_ex_bubble),
        .pc_hold(pc_hold), .if_id_flush(if_id_flush), .busy_vec(busy_vec)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending write count per register and remaining flush cycles.
    int pend_m [32];
    int flush_left_m;

    typedef struct packed {
        logic        rdy;
        logic        iss;
        logic        bub;
        logic        hold;
        logic        fl;
        logic [31:0] busy;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        logic hz;
        e = '0;
        if (Reset !== 1'b1) return e;
        for (int i = 0; i < 32; i++) e.busy[i] = (pend_m[i] > 0);
        if (flush_left_m > 0) begin
            e.bub = 1'b1; e.fl = 1'b1; e.rdy = 1'b1;
            return e;
        end
        hz = id_valid && ((uses_rs && pend_m[readSelect1] > 0)
                       || (uses_rt && pend_m[readSelect2] > 0)
                       || (dest_valid && dest_sel != 5'd0 && pend_m[dest_sel] == MAXV));
        if (hz) begin
            e.bub = 1'b1; e.hold = 1'b1;
        end else if (id_valid) begin
            e.iss = 1'b1; e.rdy = 1'b1; e.fl = PCSource;
        end else begin
            e.bub = 1'b1; e.rdy = 1'b1;
        end
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        logic dec_ok;
        if (Reset !== 1'b1) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 0;
            flush_left_m = 0;
            return;
        end
        e = model_out();
        dec_ok = writeEnable && writeSelect != 5'd0 && pend_m[writeSelect] > 0;
        if (flush_left_m > 0) flush_left_m = flush_left_m - 1;
        else if (e.iss && PCSource) flush_left_m = PENALTY;
        if (e.iss && dest_valid && dest_sel != 5'd0) pend_m[dest_sel] = pend_m[dest_sel] + 1;
        if (dec_ok) pend_m[writeSelect] = pend_m[writeSelect] - 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Every stimulus cycle advances through here so the model steps on the same edge as the DUT.
    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_in();
        id_valid = 0; uses_rs = 0; uses_rt = 0; dest_valid = 0; PCSource = 0; writeEnable = 0;
        readSelect1 = 0; readSelect2 = 0; dest_sel = 0; writeSelect = 0;
    endtask

    always @(negedge Clk) begin
        exp_t ce;
        ce = model_out();
        chk("cmp_id_ready",     32'(id_ready),     32'(ce.rdy));
        chk("cmp_id_issue",     32'(id_issue),     32'(ce.iss));
        chk("cmp_id_ex_bubble", 32'(id_ex_bubble), 32'(ce.bub));
        chk("cmp_pc_hold",      32'(pc_hold),      32'(ce.hold));
        chk("cmp_if_id_flush",  32'(if_id_flush),  32'(ce.fl));
        chk("cmp_busy_vec",     busy_vec,          ce.busy);
    end

    initial begin
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        flush_left_m = 0;
        Reset = 1'b0;
        idle_in();
        cyc(); cyc();
        chk("rst_ready",  32'(id_ready), 32'd0);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rst_busy",   busy_vec, 32'd0);
        Reset = 1'b1;
        settle();
        chk("rel_ready", 32'(id_ready), 32'd1);
        chk("rel_busy",  busy_vec, 32'd0);
        cyc();

        // RAW on register 5
        idle_in(); id_valid = 1; dest_valid = 1; dest_sel = 5;
        settle(); chk("raw_issue1", 32'(id_issue), 32'd1);
        cyc();
        idle_in(); id_valid = 1; uses_rs = 1; readSelect1 = 5;
        settle();
        chk("raw_bubble", 32'(id_ex_bubble), 32'd1);
        chk("raw_hold",   32'(pc_hold), 32'd1);
        chk("raw_busy",   busy_vec, 32'h0000_0020);
        cyc();
        writeEnable = 1; writeSelect = 5;
        settle(); chk("raw_wb_nobypass", 32'(id_ex_bubble), 32'd1);
        cyc();
        writeEnable = 0;
        settle();
        chk("raw_issue_after", 32'(id_issue), 32'd1);
        chk("raw_busy_clear",  busy_vec, 32'd0);
        cyc();

        // Same-cycle issue and write-back on register 7
        idle_in(); id_valid = 1; dest_valid = 1; dest_sel = 7;
        cyc();
        writeEnable = 1; writeSelect = 7;
        settle(); chk("same_issue", 32'(id_issue), 32'd1);
        cyc();
        idle_in();
        settle(); chk("same_busy", busy_vec, 32'h0000_0080);
        writeEnable = 1; writeSelect = 7;
        cyc();
        writeEnable = 0;
        settle(); chk("same_drain", busy_vec, 32'd0);

        // Register 0 is never tracked
        idle_in(); id_valid = 1; dest_valid = 1; dest_sel = 0;
        cyc(); cyc(); cyc();
        dest_valid = 0; uses_rs = 1; readSelect1 = 0;
        settle();
        chk("r0_issue", 32'(id_issue), 32'd1);
        chk("r0_busy",  busy_vec, 32'd0);
        cyc();

        // Saturation on register 9
        idle_in(); id_valid = 1; dest_valid = 1; dest_sel = 9;
        cyc(); cyc(); cyc();
        settle();
        chk("sat_stall", 32'(id_ex_bubble), 32'd1);
        chk("sat_busy",  busy_vec, 32'h0000_0200);
        writeEnable = 1; writeSelect = 9;
        cyc();
        writeEnable = 0;
        settle(); chk("sat_issue", 32'(id_issue), 32'd1);
        cyc();
        idle_in(); writeEnable = 1; writeSelect = 9;
        cyc(); cyc(); cyc();
        writeEnable = 0;
        settle(); chk("sat_drained", busy_vec, 32'd0);

        // Taken branch: flush asserted on the issue cycle plus PENALTY cycles
        idle_in(); id_valid = 1; PCSource = 1;
        settle();
        chk("br_flush0", 32'(if_id_flush), 32'd1);
        chk("br_issue0", 32'(id_issue), 32'd1);
        cyc();
        settle();
        chk("br_flush1",   32'(if_id_flush), 32'd1);
        chk("br_noissue1", 32'(id_issue), 32'd0);
        cyc();
        settle(); chk("br_flush2", 32'(if_id_flush), 32'd1);
        cyc();
        PCSource = 0;
        settle();
        chk("br_flush3", 32'(if_id_flush), 32'd0);
        chk("br_issue3", 32'(id_issue), 32'd1);
        cyc();

        // Reset asserted while stalled
        idle_in(); id_valid = 1; dest_valid = 1; dest_sel = 3;
        cyc();
        idle_in(); id_valid = 1; uses_rt = 1; readSelect2 = 3;
        settle(); chk("rs_stall", 32'(id_ex_bubble), 32'd1);
        cyc();
        Reset = 1'b0;
        #1;
        chk("rs_ready0",  32'(id_ready), 32'd0);
        chk("rs_bubble0", 32'(id_ex_bubble), 32'd0);
        chk("rs_hold0",   32'(pc_hold), 32'd0);
        cyc(); cyc();
        idle_in(); Reset = 1'b1;
        settle();
        chk("rs_ready1", 32'(id_ready), 32'd1);
        chk("rs_busy1",  busy_vec, 32'd0);
        cyc();

        // Randomized traffic concentrated on a few registers to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_valid    = ($urandom_range(0, 99) < 80);
            uses_rs     = 1'($urandom_range(0, 1));
            uses_rt     = 1'($urandom_range(0, 1));
            dest_valid  = ($urandom_range(0, 99) < 70);
            readSelect1 = 5'($urandom_range(0, 7));
            readSelect2 = 5'($urandom_range(0, 7));
            dest_sel    = 5'($urandom_range(0, 7));
            PCSource    = ($urandom_range(0, 99) < 10);
            writeEnable = ($urandom_range(0, 99) < 45);
            writeSelect = 5'($urandom_range(0, 7));
            Reset       = ($urandom_range(0, 399) != 0);
            cyc();
        end
        Reset = 1'b1;
        idle_in();
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
